program_loader: RTL



---
 rtl/program_loader.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Framed program image loader: LE word count, payload words to BRAM port A.
// Define PROGRAM_LOADER_CSUM_EN to require a trailing mod-256 payload checksum.
`timescale 1ns/1ps
module program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic [31:0] inst_addra,
  output logic [31:0] inst_dina,
  output logic [3:0]  inst_wea,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_cause,
  output logic [15:0] words_done
);

`ifdef PROGRAM_LOADER_CSUM_EN
  typedef enum logic [2:0] {
    IDLE, HDR, PAYLOAD, CSUM, DONE, ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, HDR, PAYLOAD, DONE, ERR
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] shreg_q, shreg_d;
  logic [31:0] count_q, count_d;
  logic [31:0] addr_d, dina_d;
  logic [3:0]  wea_d;
  logic        busy_d, done_d, err_d;
  logic [1:0]  cause_d;
  logic [15:0] wd_d;
`ifdef PROGRAM_LOADER_CSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  // first byte ends up in bits 7:0 after four shifts
  logic [31:0] shifted;
  logic [15:0] wd_inc;
  assign shifted = {byte_data, shreg_q[31:8]};
  assign wd_inc  = words_done + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      shreg_q    <= 32'd0;
      count_q    <= 32'd0;
      inst_addra <= 32'd0;
      inst_dina  <= 32'd0;
      inst_wea   <= 4'h0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_cause  <= 2'b00;
      words_done <= 16'd0;
`ifdef PROGRAM_LOADER_CSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      count_q    <= count_d;
      inst_addra <= addr_d;
      inst_dina  <= dina_d;
      inst_wea   <= wea_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      err_cause  <= cause_d;
      words_done <= wd_d;
`ifdef PROGRAM_LOADER_CSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    count_d = count_q;
    addr_d  = inst_addra;
    dina_d  = inst_dina;
    wea_d   = 4'h0;
    done_d  = done;
    err_d   = err;
    cause_d = err_cause;
    wd_d    = words_done;
`ifdef PROGRAM_LOADER_CSUM_EN
    csum_d  = csum_q;
`endif
    if (start) begin
      state_d = HDR;
      cnt_d   = 2'd0;
      shreg_d = 32'd0;
      count_d = 32'd0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      cause_d = 2'b00;
      wd_d    = 16'd0;
`ifdef PROGRAM_LOADER_CSUM_EN
      csum_d  = 8'd0;
`endif
    end else if (byte_valid) begin
      case (state_q)
        HDR: begin
          shreg_d = shifted;
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            count_d = shifted;
            if (shifted > MAX_WORDS) begin
              state_d = ERR;
              err_d   = 1'b1;
              cause_d = 2'b01;
            end else if (shifted == 32'd0) begin
`ifdef PROGRAM_LOADER_CSUM_EN
              state_d = CSUM;
`else
              state_d = DONE;
              done_d  = 1'b1;
`endif
            end else begin
              state_d = PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          shreg_d = shifted;
          cnt_d   = cnt_q + 2'd1;
`ifdef PROGRAM_LOADER_CSUM_EN
          csum_d  = csum_q + byte_data;
`endif
          if (cnt_q == 2'd3) begin
            wea_d  = 4'hF;
            addr_d = BASE_ADDR + {14'd0, words_done, 2'b00};
            dina_d = shifted;
            wd_d   = wd_inc;
            if ({16'd0, wd_inc} == count_q) begin
`ifdef PROGRAM_LOADER_CSUM_EN
              state_d = CSUM;
`else
              state_d = DONE;
              done_d  = 1'b1;
`endif
            end
          end
        end
`ifdef PROGRAM_LOADER_CSUM_EN
        CSUM: begin
          if (byte_data == csum_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
            cause_d = 2'b10;
          end
        end
`endif
        default: ;
      endcase
    end
    busy_d = (state_d == HDR) || (state_d == PAYLOAD);
`ifdef PROGRAM_LOADER_CSUM_EN
    busy_d = busy_d || (state_d == CSUM);
`endif
  end

endmodule
